// File: rtl/serial_alu_sequencer_if.sv
// Start/busy/done handshake and result bus for the bit-serial ALU sequencer.
interface serial_alu_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, op,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, a, b, op,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: one bit position per clock, carry and SLT chain held in flops.
// Result and flags become visible on the edge entering DONE and hold until the next start.
module serial_alu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_alu_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_k;
    logic               r_ans;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic               r_busy;
    logic               r_done;

    logic               w_last;
    logic               w_is_slt;
    logic               w_is_arith;
    logic [CNT_W-1:0]   w_idx;
    logic               w_a_bit;
    logic               w_b_raw;
    logic               w_b_bit;
    logic               w_carry_nxt;
    logic               w_bit;
    logic               w_k_nxt;
    logic               w_ans_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_final;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One-bit slice for the current position; SLT walks MSB first
    always_comb begin
        w_last      = (r_cnt == CNT_W'(WIDTH - 1));
        w_is_slt    = (r_op == OP_SLT);
        w_is_arith  = (r_op == OP_ADD) || (r_op == OP_SUB);
        w_idx       = w_is_slt ? (CNT_W'(WIDTH - 1) - r_cnt) : r_cnt;
        w_a_bit     = r_a[w_idx];
        w_b_raw     = r_b[w_idx];
        w_b_bit     = w_b_raw ^ (r_op == OP_SUB);
        w_carry_nxt = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);

        w_bit = 1'b0;
        case (r_op)
            OP_ADD,
            OP_SUB:  w_bit = w_a_bit ^ w_b_bit ^ r_carry;
            OP_XOR:  w_bit = w_a_bit ^ w_b_raw;
            OP_AND:  w_bit = w_a_bit & w_b_raw;
            OP_NAND: w_bit = ~(w_a_bit & w_b_raw);
            OP_NOR:  w_bit = ~(w_a_bit | w_b_raw);
            OP_OR:   w_bit = w_a_bit | w_b_raw;
            default: w_bit = 1'b0;
        endcase

        // First differing bit decides: on the sign bit a=1 means a is smaller, below it b=1 does
        w_k_nxt   = r_k;
        w_ans_nxt = r_ans;
        if (r_k && (w_a_bit != w_b_raw)) begin
            w_k_nxt   = 1'b0;
            w_ans_nxt = (r_cnt == '0) ? w_a_bit : w_b_raw;
        end

        w_acc_nxt        = r_acc;
        w_acc_nxt[w_idx] = w_bit;
        w_final          = w_is_slt ? {{(WIDTH-1){1'b0}}, w_ans_nxt} : w_acc_nxt;
    end

    // Operand capture, serial datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_k         <= 1'b0;
            r_ans       <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (r_state == S_RUN) && w_last;
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_op    <= bus.op;
                r_cnt   <= '0;
                r_carry <= (bus.op == OP_SUB);
                r_k     <= 1'b1;
                r_ans   <= 1'b0;
                r_acc   <= '0;
            end else if (r_state == S_RUN) begin
                r_carry <= w_carry_nxt;
                r_k     <= w_k_nxt;
                r_ans   <= w_ans_nxt;
                r_acc   <= w_acc_nxt;
                if (w_last) begin
                    r_result    <= w_final;
                    r_carry_out <= w_is_arith ? w_carry_nxt : 1'b0;
                    r_overflow  <= w_is_arith ? (r_carry ^ w_carry_nxt) : 1'b0;
                    r_zero      <= (w_final == '0);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer at WIDTH=8: directed and random ops against an arithmetic model.
module tb_serial_alu_sequencer;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_alu_sequencer_if #(.WIDTH(W)) bus ();

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] s;
        co = 1'b0;
        ov = 1'b0;
        case (o)
            3'd0: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                r  = x - y;
                co = (x >= y);
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x ^ y;
            3'd3: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            3'd4: r = x & y;
            3'd5: r = ~(x & y);
            3'd6: r = ~(x | y);
            default: r = x | y;
        endcase
    endfunction

    // Issue one op and wait for done; returns outputs seen in the done cycle
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic co, output logic ov, output logic z,
                          output int lat, output int bcyc, output bit to);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcyc = bus.busy ? 1 : 0;
        to   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            if (bus.busy) bcyc++;
        end
        r  = bus.result;
        co = bus.carry_out;
        ov = bus.overflow;
        z  = bus.zero;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = '0;
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b z=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Directed table: each row checked for result/flags and latency
    task automatic test_directed;
        logic [2:0]   ops [15] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3,
                                   3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd0};
        logic [W-1:0] as  [15] = '{8'h7F, 8'h05, 8'h80, 8'hFF, 8'h01, 8'h10, 8'h03,
                                   8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hFF, 8'h00, 8'h80};
        logic [W-1:0] bs  [15] = '{8'h01, 8'h05, 8'h01, 8'h01, 8'hFF, 8'h10, 8'h05,
                                   8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h01, 8'h80};
        logic [W-1:0] er  [15] = '{8'h80, 8'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h01,
                                   8'h66, 8'h88, 8'h77, 8'h11, 8'hEE, 8'h00, 8'hFF, 8'h00};
        logic [2:0]   ef  [15] = '{3'b010, 3'b101, 3'b110, 3'b000, 3'b001, 3'b001, 3'b000,
                                   3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b111};
        logic [W-1:0] r;
        logic co, ov, z;
        int lat, bcyc;
        bit to;
        for (int i = 0; i < 15; i++) begin
            run_op(ops[i], as[i], bs[i], r, co, ov, z, lat, bcyc, to);
            checks++;
            if (to || lat != 8 || bcyc != 8) begin
                errors++;
                $display("FAIL directed_timing[%0d]: got timeout=%0d latency=%0d busy_cycles=%0d, want 0/8/8",
                         i, to, lat, bcyc);
            end
            checks++;
            if ({r, co, ov, z} !== {er[i], ef[i]}) begin
                errors++;
                $display("FAIL directed_value[%0d] op=%0d a=%h b=%h: got r=%h co=%b ov=%b z=%b, want r=%h co/ov/z=%b",
                         i, ops[i], as[i], bs[i], r, co, ov, z, er[i], ef[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 8'h00 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse_width: got done=%b busy=%b result=%h zero=%b, want 0/0/00/1",
                     bus.done, bus.busy, bus.result, bus.zero);
        end
    endtask

    task automatic test_random;
        logic [2:0]   o;
        logic [W-1:0] x, y, r, er;
        logic co, ov, z, eco, eov;
        int lat, bcyc;
        bit to;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            if (i % 10 == 0) y = x;
            model(o, x, y, er, eco, eov);
            run_op(o, x, y, r, co, ov, z, lat, bcyc, to);
            checks++;
            if (to || lat != 8 || {r, co, ov, z} !== {er, eco, eov, (er == '0)}) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got r=%h co=%b ov=%b z=%b lat=%0d, want r=%h co=%b ov=%b z=%b lat=8",
                         i, o, x, y, r, co, ov, z, lat, er, eco, eov, (er == '0));
            end
        end
    endtask

    // start pulsed in the 3rd RUN cycle must have no effect
    task automatic test_start_ignored;
        int lat;
        bit to;
        logic [W-1:0] r;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 8'h21;
        bus.b     = 8'h13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd7;
                bus.a     = 8'hF0;
                bus.b     = 8'h0F;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        r = bus.result;
        checks++;
        if (to || lat != 8 || r !== 8'h34) begin
            errors++;
            $display("FAIL start_ignored: got timeout=%0d latency=%0d result=%h, want 0/8/34", to, lat, r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_not_queued: got busy=%b done=%b, want 0/0", bus.busy, bus.done);
        end
    endtask

    // start held during DONE launches the next op immediately
    task automatic test_back_to_back;
        logic [W-1:0] r;
        logic co, ov, z;
        int lat, bcyc;
        bit to;
        run_op(3'd4, 8'hF3, 8'h3C, r, co, ov, z, lat, bcyc, to);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (to || r !== 8'h30 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got first=%h timeout=%0d busy=%b done=%b, want 30/0/1/0",
                     r, to, bus.busy, bus.done);
        end
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || lat != 8 || {bus.result, bus.carry_out, bus.overflow, bus.zero} !== {8'hF0, 3'b000}) begin
            errors++;
            $display("FAIL b2b_second: got timeout=%0d latency=%0d r=%h co=%b ov=%b z=%b, want lat 8 r=f0 co/ov/z=000",
                     to, lat, bus.result, bus.carry_out, bus.overflow, bus.zero);
        end
    endtask

    // Asynchronous reset in the middle of RUN
    task automatic test_reset_mid_run;
        logic [W-1:0] r;
        logic co, ov, z;
        int lat, bcyc;
        bit to, seen_done;
        run_op(3'd0, 8'h90, 8'h90, r, co, ov, z, lat, bcyc, to);
        checks++;
        if (to || {r, co, ov, z} !== {8'h20, 3'b110}) begin
            errors++;
            $display("FAIL pre_reset_add: got r=%h co=%b ov=%b z=%b, want 20/1/1/0", r, co, ov, z);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 8'h55;
        bus.b     = 8'h22;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h co=%b ov=%b z=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_op: got done_seen=%b busy=%b, want 0/0", seen_done, bus.busy);
        end
        run_op(3'd0, 8'h01, 8'h01, r, co, ov, z, lat, bcyc, to);
        checks++;
        if (to || lat != 8 || {r, co, ov, z} !== {8'h02, 3'b000}) begin
            errors++;
            $display("FAIL post_reset_add: got timeout=%0d lat=%0d r=%h co=%b ov=%b z=%b, want 0/8/02/000",
                     to, lat, r, co, ov, z);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
- Multi-cycle, bit-serial ALU front end. It accepts a WIDTH-bit operand pair plus a 3-bit op on a start/busy/done handshake and evaluates one bit position per clock using the 1-bit slice function (add, logic ops, set-less-than chain).
- Carry/SLT chain state lives in flops rather than in ripple wiring.
- Sits directly upstream of the result/flag consumer and replaces a WIDTH-slice ripple array where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- op  input  3  000 ADD, 001 SUB, 010 XOR, 011 SLT (signed), 100 AND, 101 NAND, 110 NOR, 111 OR
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags are valid from this cycle until the next accepted start
- result  output  WIDTH  operation result
- carry_out  output  1  final carry for ADD/SUB; 0 for other ops
- overflow  output  1  signed overflow for ADD/SUB; 0 for other ops
- zero  output  1  result == 0

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE; busy = 0, done = 0.
  - result, carry_out, overflow and zero all reset to 0.
  - Operand registers, bit counter and chain flops are cleared.
  - The operation in progress is abandoned and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start = 1 at an edge captures a, b and op, clears the counter, loads the chain registers, and moves to RUN.
  - RUN: each edge processes exactly one bit and increments the counter. The edge that processes the WIDTH-th bit moves to DONE.
  - DONE: done = 1 for exactly one cycle, with result and flags updated. The next edge moves to RUN if start = 1 (new capture, back-to-back) or to IDLE otherwise.
  - start in RUN is ignored; it is neither queued nor does it restart the operation.
- Latency: done is high in the cycle that follows the WIDTH-th rising edge after the accepting edge. For WIDTH = 8 there are exactly 8 edges from the accepting edge to the done cycle.
- Bit order:
  - ADD, SUB and the logic ops run LSB first (index = count).
  - SLT runs MSB first (index = WIDTH-1-count).
- ADD: carry flop is loaded with 0. Each step: sum bit = a^b^c, carry = majority(a, b, c).
- SUB: same as ADD with b inverted per bit and the carry loaded with 1.
- Overflow: computed on the MSB step as carry_in_to_MSB XOR carry_out_of_MSB.
- Logic ops: per-bit XOR, AND, NAND, NOR, OR; the carry flop is unused.
- SLT chain: flops k (still equal) and ans are loaded with k = 1, ans = 0.
  - On the MSB step (first), when k = 1 and the bits differ, a = 1 / b = 0 sets ans = 1 (signed), and k goes to 0.
  - On later steps, when k = 1 and the bits differ, a = 0 / b = 1 sets ans = 1, a = 1 / b = 0 leaves ans = 0, and k goes to 0.
  - Once k = 0, ans passes through unchanged.
  - Equal bits keep k = 1.
  - Final result = {WIDTH-1 zeros, ans}; equal operands give 0.
- Result bits are written into a result register at their index. The visible result, carry_out, overflow and zero outputs update only on the edge entering DONE; they hold their previous values while in RUN.
- Full-range operands are wrapped modulo 2^WIDTH; there is no saturation.

Test Plan (WIDTH=8):
- ADD a=8'h7F, b=8'h01: result 8'h80, carry_out 0, overflow 1, zero 0. done pulses for exactly 1 cycle, 8 edges after the accepting edge, and busy is high for 8 cycles.
- SUB a=8'h05, b=8'h05: result 8'h00, carry_out 1, zero 1, overflow 0. SUB a=8'h80, b=8'h01: result 8'h7F, overflow 1.
- SLT: a=8'hFF, b=8'h01 gives result 8'h01. a=8'h01, b=8'hFF gives 8'h00. a=8'h10, b=8'h10 gives 8'h00 with zero 1. a=8'h03, b=8'h05 gives 8'h01.
- Logic, a=8'hCC, b=8'hAA: XOR 8'h66, AND 8'h88, NAND 8'h77, NOR 8'h11, OR 8'hEE. carry_out and overflow stay 0 for all five.
- Handshake:
  - start pulsed on the 3rd RUN cycle with different operands: ignored, and the first result is unchanged.
  - start held high during DONE: the new operation is accepted, busy rises on the next edge, and its done follows 8 edges later.
- Reset: rst_n driven low mid-RUN between edges. Outputs go to 0 immediately, with no clock edge needed. No done pulse occurs. After release, a fresh ADD 8'h01 + 8'h01 returns 8'h02.
